cici_rate_sequencer: RTL and testbench

//  Single-clock sequencer for the CIC interpolator. Generates the slow-rate (comb) and fast-rate
//  (integrator) enables from one clock, accepts upstream samples via valid/ready once per slow

---
 rtl/cici_rate_sequencer_if.sv | 29 ++
 rtl/cici_rate_sequencer.sv | 141 ++++++++++++++
 tb/tb_cici_rate_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cici_rate_sequencer_if.sv
// Sample and control bundle between an upstream source and the CIC rate sequencer.
// master drives requests and samples; slave (the sequencer) returns the handshake, enables and status.
interface cici_rate_sequencer_if #(
    parameter int gp_data_width = 8,
    parameter int gp_rate_width = 5
);
    logic                            i_start;
    logic                            i_stop;
    logic        [gp_rate_width-1:0] i_rate;
    logic                            i_valid;
    logic signed [gp_data_width-1:0] i_data;
    logic                            o_ready;
    logic signed [gp_data_width-1:0] o_data;
    logic                            o_slow_ena;
    logic                            o_fast_ena;
    logic                            o_busy;
    logic                            o_underrun;
    logic        [1:0]               o_state;

    modport master (
        output i_start, i_stop, i_rate, i_valid, i_data,
        input  o_ready, o_data, o_slow_ena, o_fast_ena, o_busy, o_underrun, o_state
    );

    modport slave (
        input  i_start, i_stop, i_rate, i_valid, i_data,
        output o_ready, o_data, o_slow_ena, o_fast_ena, o_busy, o_underrun, o_state
    );
endinterface

// File: rtl/cici_rate_sequencer.sv
// Slow/fast enable sequencer for a CIC interpolator: accepts one sample per slow frame,
// runs until stopped, then zero-flushes the filter for order*delay frames before going idle.
module cici_rate_sequencer #(
    parameter int gp_data_width = 8,
    parameter int gp_max_rate   = 16,
    parameter int gp_rate_width = $clog2(gp_max_rate + 1),
    parameter int gp_order      = 3,
    parameter int gp_diff_delay = 1
) (
    input logic                 i_clk,
    input logic                 i_rst,
    cici_rate_sequencer_if.slave bus
);
    localparam int RW        = gp_rate_width;
    localparam int FLUSH_LEN = gp_order * gp_diff_delay;
    localparam int FW        = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [RW-1:0] MAX_RATE   = RW'(gp_max_rate);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t                    state_r, state_nx_s;
    logic [RW-1:0]             cnt_r, cnt_nx_s, cnt_inc_s;
    logic [RW-1:0]             rate_q_r, rate_nx_s, rate_latch_s;
    logic [FW-1:0]             flush_cnt_r, flush_nx_s;
    logic [gp_data_width-1:0]  data_r, data_nx_s;
    logic                      underrun_r, underrun_nx_s;
    logic                      stop_pend_r, stop_pend_nx_s;
    logic                      b_s, stop_now_s;

    assign b_s        = (cnt_r == (rate_q_r - RW'(1)));
    assign cnt_inc_s  = b_s ? {RW{1'b0}} : (cnt_r + RW'(1));
    // A stop arriving on a boundary cycle must already suppress that boundary's handshake.
    assign stop_now_s = stop_pend_r | bus.i_stop;

    // Rate to latch on an accepted start: zero maps to 1, oversize clamps to the maximum.
    always_comb begin
        rate_latch_s = bus.i_rate;
        if (bus.i_rate == {RW{1'b0}}) begin
            rate_latch_s = RW'(1);
        end else if (bus.i_rate > MAX_RATE) begin
            rate_latch_s = MAX_RATE;
        end else begin
            rate_latch_s = bus.i_rate;
        end
    end

    // Next-state and datapath decisions for IDLE/RUN/FLUSH.
    always_comb begin
        state_nx_s     = state_r;
        cnt_nx_s       = cnt_r;
        rate_nx_s      = rate_q_r;
        flush_nx_s     = flush_cnt_r;
        data_nx_s      = data_r;
        underrun_nx_s  = underrun_r;
        stop_pend_nx_s = stop_pend_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nx_s = {RW{1'b0}};
                if (bus.i_start && !bus.i_stop) begin
                    state_nx_s     = ST_RUN;
                    rate_nx_s      = rate_latch_s;
                    underrun_nx_s  = 1'b0;
                    data_nx_s      = {gp_data_width{1'b0}};
                    stop_pend_nx_s = 1'b0;
                    flush_nx_s     = {FW{1'b0}};
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                cnt_nx_s = cnt_inc_s;
                if (b_s) begin
                    if (stop_now_s) begin
                        state_nx_s     = ST_FLUSH;
                        data_nx_s      = {gp_data_width{1'b0}};
                        flush_nx_s     = {FW{1'b0}};
                        stop_pend_nx_s = 1'b0;
                    end else if (bus.i_valid) begin
                        data_nx_s = bus.i_data;
                    end else begin
                        data_nx_s     = {gp_data_width{1'b0}};
                        underrun_nx_s = 1'b1;
                    end
                end else begin
                    stop_pend_nx_s = stop_now_s;
                end
            end
            ST_FLUSH: begin
                cnt_nx_s  = cnt_inc_s;
                data_nx_s = {gp_data_width{1'b0}};
                if (b_s && (flush_cnt_r == FLUSH_LAST)) begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = {RW{1'b0}};
                end else if (b_s) begin
                    flush_nx_s = flush_cnt_r + FW'(1);
                end else begin
                    flush_nx_s = flush_cnt_r;
                end
            end
            default: begin
                state_nx_s     = ST_IDLE;
                cnt_nx_s       = {RW{1'b0}};
                stop_pend_nx_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {RW{1'b0}};
            rate_q_r    <= RW'(1);
            flush_cnt_r <= {FW{1'b0}};
            data_r      <= {gp_data_width{1'b0}};
            underrun_r  <= 1'b0;
            stop_pend_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            rate_q_r    <= rate_nx_s;
            flush_cnt_r <= flush_nx_s;
            data_r      <= data_nx_s;
            underrun_r  <= underrun_nx_s;
            stop_pend_r <= stop_pend_nx_s;
        end
    end

    assign bus.o_fast_ena = (state_r != ST_IDLE);
    assign bus.o_slow_ena = (state_r != ST_IDLE) & b_s;
    assign bus.o_ready    = (state_r == ST_RUN) & b_s & ~stop_now_s;
    assign bus.o_data     = data_r;
    assign bus.o_busy     = (state_r != ST_IDLE);
    assign bus.o_underrun = underrun_r;
    assign bus.o_state    = state_r;
endmodule

// File: tb/tb_cici_rate_sequencer.sv
// Directed bench for cici_rate_sequencer at R in {0,1,2,4,20}, N=3, M=1.
module tb_cici_rate_sequencer;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    cici_rate_sequencer_if bus ();

    cici_rate_sequencer dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [4:0] r);
        bus.i_rate  = r;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
    endtask

    task automatic stop_and_drain();
        int n;
        bus.i_stop = 1'b1;
        step();
        bus.i_stop = 1'b0;
        n = 0;
        while (bus.o_state !== 2'b00 && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (bus.o_state !== 2'b00 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL drain: got state %b busy %b expected 00 0", bus.o_state, bus.o_busy);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.o_ready, bus.o_slow_ena, bus.o_fast_ena, bus.o_busy, bus.o_underrun, bus.o_state, bus.o_data} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {bus.o_ready, bus.o_slow_ena, bus.o_fast_ena, bus.o_busy, bus.o_underrun, bus.o_state, bus.o_data});
        end
        rst = 1'b0;
        bus.i_valid = 1'b0;
        start_run(5'd4);
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (bus.o_underrun !== 1'b1 || bus.o_state !== 2'b01) begin
            errors++;
            $display("FAIL pre_reset_run: got underrun %b state %b expected 1 01", bus.o_underrun, bus.o_state);
        end
        step();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_ready, bus.o_slow_ena, bus.o_fast_ena, bus.o_busy, bus.o_underrun, bus.o_state, bus.o_data} !== 14'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0",
                     {bus.o_ready, bus.o_slow_ena, bus.o_fast_ena, bus.o_busy, bus.o_underrun, bus.o_state, bus.o_data});
        end
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (bus.o_state !== 2'b00 || bus.o_busy !== 1'b0 || bus.o_fast_ena !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset: got state %b busy %b fast %b expected 00 0 0",
                         bus.o_state, bus.o_busy, bus.o_fast_ena);
            end
        end
    endtask

    task automatic test_steady();
        logic       exp_rdy;
        logic [7:0] exp_data;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'sd1;
        start_run(5'd4);
        for (int c = 0; c < 15; c++) begin
            bus.i_data = 8'(c / 4 + 1);
            exp_rdy  = ((c % 4) == 3);
            exp_data = (c < 4) ? 8'd0 : 8'(c / 4);
            checks++;
            if ({bus.o_ready, bus.o_slow_ena, bus.o_fast_ena} !== {exp_rdy, exp_rdy, 1'b1}) begin
                errors++;
                $display("FAIL steady_enables c=%0d: got %b expected %b", c,
                         {bus.o_ready, bus.o_slow_ena, bus.o_fast_ena}, {exp_rdy, exp_rdy, 1'b1});
            end
            checks++;
            if (bus.o_data !== exp_data) begin
                errors++;
                $display("FAIL steady_data c=%0d: got %0d expected %0d", c, bus.o_data, exp_data);
            end
            step();
        end
        stop_and_drain();
    endtask

    task automatic test_underrun();
        logic [7:0] exp_data;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'sd9;
        start_run(5'd4);
        for (int c = 0; c < 16; c++) begin
            bus.i_valid = (c != 7);
            bus.i_data  = (c < 8) ? 8'sd9 : 8'sd10;
            exp_data = (c < 4) ? 8'd0 : (c < 8) ? 8'd9 : (c < 12) ? 8'd0 : 8'd10;
            checks++;
            if (bus.o_data !== exp_data || bus.o_underrun !== (c >= 8)) begin
                errors++;
                $display("FAIL underrun c=%0d: got data %0d ur %b expected %0d %b", c,
                         bus.o_data, bus.o_underrun, exp_data, (c >= 8));
            end
            step();
        end
        bus.i_valid = 1'b1;
        stop_and_drain();
        checks++;
        if (bus.o_underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_sticky_idle: got %b expected 1", bus.o_underrun);
        end
        start_run(5'd4);
        checks++;
        if (bus.o_underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_clear_on_start: got %b expected 0", bus.o_underrun);
        end
        stop_and_drain();
    endtask

    task automatic test_stop();
        bus.i_valid = 1'b1;
        bus.i_data  = 8'sd7;
        start_run(5'd4);
        for (int k = 0; k < 5; k++) step();
        checks++;
        if (bus.o_data !== 8'sd7 || bus.o_state !== 2'b01) begin
            errors++;
            $display("FAIL stop_pre: got data %0d state %b expected 7 01", bus.o_data, bus.o_state);
        end
        bus.i_stop = 1'b1;
        step();
        bus.i_stop = 1'b0;
        step();
        checks++;
        if (bus.o_state !== 2'b01 || bus.o_slow_ena !== 1'b1 || bus.o_ready !== 1'b0) begin
            errors++;
            $display("FAIL stop_boundary: got state %b slow %b ready %b expected 01 1 0",
                     bus.o_state, bus.o_slow_ena, bus.o_ready);
        end
        step();
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (bus.o_state !== 2'b10 || bus.o_data !== 8'sd0 || bus.o_ready !== 1'b0 ||
                bus.o_fast_ena !== 1'b1 || bus.o_slow_ena !== ((k % 4) == 3)) begin
                errors++;
                $display("FAIL flush k=%0d: got state %b data %0d ready %b fast %b slow %b", k,
                         bus.o_state, bus.o_data, bus.o_ready, bus.o_fast_ena, bus.o_slow_ena);
            end
            step();
        end
        checks++;
        if (bus.o_state !== 2'b00 || bus.o_busy !== 1'b0 || bus.o_fast_ena !== 1'b0) begin
            errors++;
            $display("FAIL flush_end: got state %b busy %b fast %b expected 00 0 0",
                     bus.o_state, bus.o_busy, bus.o_fast_ena);
        end
    endtask

    task automatic test_rate_clamp();
        int n;
        bus.i_valid = 1'b1;
        start_run(5'd0);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (bus.o_slow_ena !== 1'b1 || bus.o_ready !== 1'b1) begin
                errors++;
                $display("FAIL rate0 c=%0d: got slow %b ready %b expected 1 1", c, bus.o_slow_ena, bus.o_ready);
            end
            step();
        end
        bus.i_stop = 1'b1;
        #1;
        checks++;
        if (bus.o_ready !== 1'b0 || bus.o_slow_ena !== 1'b1) begin
            errors++;
            $display("FAIL stop_on_boundary: got ready %b slow %b expected 0 1", bus.o_ready, bus.o_slow_ena);
        end
        step();
        bus.i_stop = 1'b0;
        n = 0;
        while (bus.o_state === 2'b10 && n < 50) begin
            n++;
            step();
        end
        checks++;
        if (n !== 3 || bus.o_state !== 2'b00) begin
            errors++;
            $display("FAIL rate0_flush_len: got %0d state %b expected 3 00", n, bus.o_state);
        end
        start_run(5'd20);
        for (int c = 0; c < 32; c++) begin
            checks++;
            if (bus.o_slow_ena !== ((c % 16) == 15)) begin
                errors++;
                $display("FAIL rate20 c=%0d: got slow %b expected %b", c, bus.o_slow_ena, ((c % 16) == 15));
            end
            step();
        end
        stop_and_drain();
    endtask

    task automatic test_start_stop();
        int n;
        bus.i_start = 1'b1;
        bus.i_stop  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (bus.o_state !== 2'b00 || bus.o_busy !== 1'b0) begin
                errors++;
                $display("FAIL start_and_stop: got state %b busy %b expected 00 0", bus.o_state, bus.o_busy);
            end
        end
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        start_run(5'd2);
        bus.i_stop = 1'b1;
        step();
        bus.i_stop  = 1'b0;
        bus.i_start = 1'b1;
        step();
        n = 0;
        while (bus.o_state === 2'b10 && n < 50) begin
            n++;
            step();
        end
        bus.i_start = 1'b0;
        checks++;
        if (n !== 6 || bus.o_state !== 2'b00) begin
            errors++;
            $display("FAIL flush_start_ignored: got %0d cycles state %b expected 6 00", n, bus.o_state);
        end
        step();
        checks++;
        if (bus.o_state !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_flush: got %b expected 00", bus.o_state);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        bus.i_rate  = 5'd0;
        bus.i_valid = 1'b0;
        bus.i_data  = 8'sd0;
        step();
        step();
        test_reset();
        test_steady();
        test_underrun();
        test_stop();
        test_rate_clamp();
        test_start_stop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
